toy_tage_ctr_ctrl: RTL and testbench

TOY_TAGE_CTR_CTRL -- requirements
Module: toy_tage_ctr_ctrl

---
 rtl/toy_tage_ctr_ctrl.sv | 133 +++++++++++++
 tb/tb_toy_tage_ctr_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_tage_ctr_ctrl.sv
// Saturating-counter table controller: single-port table shared between
// one-cycle lookups and three-cycle read-modify-write counter updates.
module toy_tage_ctr_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_vld,
  output logic                  pred_rdy,
  input  logic [ADDR_WIDTH-1:0] pred_idx,
  output logic                  pred_rsp_vld,
  output logic                  pred_rsp_taken,
  output logic [CTR_WIDTH-1:0]  pred_rsp_ctr,
  input  logic                  upd_vld,
  output logic                  upd_rdy,
  input  logic [ADDR_WIDTH-1:0] upd_idx,
  input  logic                  upd_taken,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPD_RD = 2'd1,
    UPD_WR = 2'd2
  } state_t;

  state_t                  state_reg;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   idx_reg;
  logic                    taken_reg;
  logic [DATA_WIDTH-1:0]   word_reg;
  logic                    rsp_vld_reg;

  logic                    pred_acc;
  logic                    upd_acc;
  logic [CTR_WIDTH-1:0]    ctr_old;
  logic [CTR_WIDTH-1:0]    ctr_new;
  logic [DATA_WIDTH-1:0]   merged_word;

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign pred_rdy = rst_n && (state_reg == IDLE);
  assign upd_rdy  = rst_n && (state_reg == IDLE) && !pred_vld;
  assign pred_acc = pred_vld && pred_rdy;
  assign upd_acc  = upd_vld && upd_rdy;
  assign busy     = (state_reg != IDLE);

  assign pred_rsp_vld   = rsp_vld_reg;
  assign pred_rsp_ctr   = mem_rd_data[CTR_WIDTH-1:0];
  assign pred_rsp_taken = mem_rd_data[CTR_WIDTH-1];

  assign ctr_old = word_reg[CTR_WIDTH-1:0];

  always_comb begin
    ctr_new = ctr_old;
    if (taken_reg && (ctr_old != {CTR_WIDTH{1'b1}})) begin
      ctr_new = ctr_old + 1'b1;
    end else if (!taken_reg && (ctr_old != {CTR_WIDTH{1'b0}})) begin
      ctr_new = ctr_old - 1'b1;
    end
  end

  // Splice the new counter into the low bits; upper bits pass through.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi = gi + 1) begin : g_merge
      if (gi < CTR_WIDTH) begin : g_ctr
        assign merged_word[gi] = ctr_new[gi];
      end else begin : g_keep
        assign merged_word[gi] = word_reg[gi];
      end
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = idx_reg;
    mem_wr_data = merged_word;
    case (state_reg)
      IDLE: begin
        if (pred_acc) begin
          mem_en   = 1'b1;
          mem_addr = pred_idx;
        end else if (upd_acc) begin
          mem_en     = 1'b1;
          mem_addr   = upd_idx;
          state_next = UPD_RD;
        end
      end
      UPD_RD: begin
        state_next = UPD_WR;
      end
      UPD_WR: begin
        mem_en     = 1'b1;
        mem_wr_en  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      taken_reg   <= 1'b0;
      word_reg    <= '0;
      rsp_vld_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      rsp_vld_reg <= pred_acc;
      if (upd_acc) begin
        idx_reg   <= upd_idx;
        taken_reg <= upd_taken;
      end
      // Read data issued at update accept is valid during UPD_RD.
      if (state_reg == UPD_RD) begin
        word_reg <= mem_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_toy_tage_ctr_ctrl.sv
// Scoreboard bench for toy_tage_ctr_ctrl: behavioural table, reference
// counter model, expected lookup responses and table writes queued in order.
module tb_toy_tage_ctr_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pred_vld;
  logic          pred_rdy;
  logic [AW-1:0] pred_idx;
  logic          pred_rsp_vld;
  logic          pred_rsp_taken;
  logic [CW-1:0] pred_rsp_ctr;
  logic          upd_vld;
  logic          upd_rdy;
  logic [AW-1:0] upd_idx;
  logic          upd_taken;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_en;
  logic          busy;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] mem_m   [logic [AW-1:0]];
  logic [DW-1:0] ref_tab [logic [AW-1:0]];
  logic [CW-1:0] rsp_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];

  toy_tage_ctr_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CTR_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_vld(pred_vld), .pred_rdy(pred_rdy), .pred_idx(pred_idx),
    .pred_rsp_vld(pred_rsp_vld), .pred_rsp_taken(pred_rsp_taken), .pred_rsp_ctr(pred_rsp_ctr),
    .upd_vld(upd_vld), .upd_rdy(upd_rdy), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'd2;
  endfunction

  function automatic logic [DW-1:0] ref_word(input logic [AW-1:0] a);
    return ref_tab.exists(a) ? ref_tab[a] : 32'd2;
  endfunction

  function automatic logic [DW-1:0] trained(input logic [DW-1:0] w, input logic t);
    int c;
    c = int'(w[1:0]);
    if (t) c = (c == 3) ? 3 : c + 1;
    else   c = (c == 0) ? 0 : c - 1;
    return {w[DW-1:2], 2'(c)};
  endfunction

  // Behavioural single-port table with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_wr_en) mem_m[mem_addr] = mem_wr_data;
      else           mem_rd_data <= mem_word(mem_addr);
    end
  end

  always @(negedge clk) begin
    if (pred_rsp_vld) begin
      vectors++;
      if (rsp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got ctr=%0d, required no response", pred_rsp_ctr);
      end else begin
        logic [CW-1:0] exp_ctr;
        exp_ctr = rsp_q.pop_front();
        if (pred_rsp_ctr !== exp_ctr || pred_rsp_taken !== exp_ctr[CW-1]) begin
          miscompares++;
          $display("FAIL rsp: got ctr=%0d taken=%0b, required ctr=%0d taken=%0b",
                   pred_rsp_ctr, pred_rsp_taken, exp_ctr, exp_ctr[CW-1]);
        end else begin
          $display("lookup rsp ctr=%0d taken=%0b ok", pred_rsp_ctr, pred_rsp_taken);
        end
      end
    end
    if (mem_en && mem_wr_en) begin
      vectors++;
      if (wr_addr_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", mem_addr, mem_wr_data);
      end else begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ea = wr_addr_q.pop_front();
        ed = wr_data_q.pop_front();
        if (mem_addr !== ea || mem_wr_data !== ed) begin
          miscompares++;
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   mem_addr, mem_wr_data, ea, ed);
        end else begin
          $display("table write addr=%h data=%h ok", mem_addr, mem_wr_data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic push_lookup(input logic [AW-1:0] idx);
    logic [DW-1:0] w;
    w = ref_word(idx);
    rsp_q.push_back(w[CW-1:0]);
  endtask

  task automatic push_update(input logic [AW-1:0] idx, input logic t);
    logic [DW-1:0] w;
    w = trained(ref_word(idx), t);
    ref_tab[idx] = w;
    wr_addr_q.push_back(idx);
    wr_data_q.push_back(w);
  endtask

  // Tasks start and end at posedge+1.
  task automatic lookup(input logic [AW-1:0] idx);
    bit ok = 0;
    pred_vld = 1'b1;
    pred_idx = idx;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (pred_rdy) begin ok = 1; push_lookup(idx); break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL lookup_accept_timeout: got pred_rdy=0, required 1");
    end
    @(posedge clk); #1;
    pred_vld = 1'b0;
  endtask

  task automatic update(input logic [AW-1:0] idx, input logic t);
    bit ok = 0;
    upd_vld   = 1'b1;
    upd_idx   = idx;
    upd_taken = t;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (upd_rdy) begin ok = 1; push_update(idx, t); break; end
      @(posedge clk); #1;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL update_accept_timeout: got upd_rdy=0, required 1");
    end
    @(posedge clk); #1;
    upd_vld = 1'b0;
  endtask

  task automatic test_reset;
    pred_vld = 1'b1; upd_vld = 1'b1; pred_idx = 32'h40; upd_idx = 32'h40; upd_taken = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pred_rdy", 32'(pred_rdy), 32'd0);
    chk("rst_upd_rdy", 32'(upd_rdy), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_rsp_vld", 32'(pred_rsp_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    upd_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    // First edge after reset release accepts the lookup of untouched 0x40.
    @(negedge clk);
    chk("first_pred_rdy", 32'(pred_rdy), 32'd1);
    chk("first_mem_en", 32'(mem_en), 32'd1);
    chk("first_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("first_mem_addr", mem_addr, 32'h40);
    push_lookup(32'h40);
    @(posedge clk); #1;
    pred_vld = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_upd_rdy", 32'(upd_rdy), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 3; i++) update(32'h40, 1'b1);
    lookup(32'h40);
    for (int i = 0; i < 3; i++) update(32'h80, 1'b0);
    lookup(32'h80);
  endtask

  task automatic test_priority;
    pred_vld = 1'b1; pred_idx = 32'h80;
    upd_vld = 1'b1; upd_idx = 32'h80; upd_taken = 1'b1;
    @(negedge clk);
    chk("prio_pred_rdy", 32'(pred_rdy), 32'd1);
    chk("prio_upd_rdy", 32'(upd_rdy), 32'd0);
    push_lookup(32'h80);
    @(posedge clk); #1;
    pred_vld = 1'b0;
    @(negedge clk);
    chk("prio_upd_rdy_next", 32'(upd_rdy), 32'd1);
    push_update(32'h80, 1'b1);
    @(posedge clk); #1;
    upd_vld = 1'b0;
    lookup(32'h80);
  endtask

  task automatic test_occupancy;
    upd_vld = 1'b1; upd_idx = 32'h100; upd_taken = 1'b0;
    @(negedge clk);
    chk("occ_upd_rdy", 32'(upd_rdy), 32'd1);
    push_update(32'h100, 1'b0);
    @(posedge clk); #1;
    upd_vld = 1'b0;
    pred_vld = 1'b1; pred_idx = 32'h100;
    @(negedge clk);
    chk("occ_rd_busy", 32'(busy), 32'd1);
    chk("occ_rd_pred_rdy", 32'(pred_rdy), 32'd0);
    chk("occ_rd_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("occ_wr_pred_rdy", 32'(pred_rdy), 32'd0);
    chk("occ_wr_mem_wr_en", 32'(mem_wr_en), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("occ_after_pred_rdy", 32'(pred_rdy), 32'd1);
    push_lookup(32'h100);
    @(posedge clk); #1;
    pred_vld = 1'b0;
  endtask

  task automatic test_upper_bits;
    update(32'h10, 1'b1);
    lookup(32'h10);
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0] idxs [4];
    idxs[0] = 32'h40; idxs[1] = 32'h80; idxs[2] = 32'h10; idxs[3] = 32'h200;
    pred_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pred_idx = idxs[i];
      @(negedge clk);
      chk("b2b_pred_rdy", 32'(pred_rdy), 32'd1);
      push_lookup(idxs[i]);
      @(posedge clk); #1;
    end
    pred_vld = 1'b0;
  endtask

  task automatic test_reset_abort;
    upd_vld = 1'b1; upd_idx = 32'h20; upd_taken = 1'b1;
    @(negedge clk);
    chk("abort_upd_rdy", 32'(upd_rdy), 32'd1);
    @(posedge clk); #1;
    upd_vld = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_mem_wr_en", 32'(mem_wr_en), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("abort_hold_wr_en", 32'(mem_wr_en), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    lookup(32'h20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pred_vld = 1'b0; upd_vld = 1'b0; pred_idx = '0; upd_idx = '0; upd_taken = 1'b0;
    rst_n = 1'b0;
    mem_rd_data = '0;
    mem_m[32'h10]   = 32'hABCD0001;
    ref_tab[32'h10] = 32'hABCD0001;
    mem_m[32'h20]   = 32'd1;
    ref_tab[32'h20] = 32'd1;
    @(posedge clk); #1;
    test_reset();
    test_saturate();
    test_priority();
    test_occupancy();
    test_upper_bits();
    test_back_to_back();
    test_reset_abort();
    for (int n = 0; n < 20; n++) begin
      if (rsp_q.size() == 0 && wr_addr_q.size() == 0) break;
      @(posedge clk); #1;
    end
    @(negedge clk);
    vectors++;
    if (rsp_q.size() != 0 || wr_addr_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d rsp and %0d writes pending, required 0", rsp_q.size(), wr_addr_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
